// File: rtl/pool_engine_if.sv
// Valid/ready element stream used for the pooling engine input and output.
// Ports (via modports):
//   master : drives valid, data; samples ready
//   slave  : samples valid, data; drives ready
interface pool_engine_if #(
   parameter int unsigned DATA_WIDTH = 8
) ();

   logic                         valid;
   logic                         ready;
   logic signed [DATA_WIDTH-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pool_engine.sv
// Streaming 2x2 / stride-2 pooling engine (max or average) for one frame at a time.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start, mode        : frame request and pooling mode (0 max, 1 avg), sampled in idle
//   frame_width/height : input frame dimensions, sampled with start
//   busy, done         : frame in progress / one-cycle end-of-frame pulse
//   cfg_error          : valid with done, set when the requested config was rejected
//   in_bus             : row-major input element stream (slave)
//   out_bus            : pooled element stream (master), single-entry output register
module pool_engine #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_WIDTH  = 64,
   parameter int unsigned DIM_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic [DIM_WIDTH-1:0] frame_width,
   input  logic [DIM_WIDTH-1:0] frame_height,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_error,
   pool_engine_if.slave         in_bus,
   pool_engine_if.master        out_bus
);

   localparam int unsigned ACC_WIDTH = DATA_WIDTH + 2;
   localparam int unsigned LB_DEPTH  = MAX_WIDTH / 2;
   localparam int unsigned LB_AW     = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]                   state, state_nx;
   logic                         mode_q, mode_nx;
   logic [DIM_WIDTH-1:0]         width_q, width_nx;
   logic [DIM_WIDTH-1:0]         height_q, height_nx;
   logic [DIM_WIDTH-1:0]         row_q, row_nx;
   logic [DIM_WIDTH-1:0]         col_q, col_nx;
   logic signed [ACC_WIDTH-1:0]  hold_q, hold_nx;
   logic                         out_valid_q, out_valid_nx;
   logic signed [DATA_WIDTH-1:0] out_data_q, out_data_nx;
   logic                         busy_nx, done_nx, cfg_error_nx;

   logic signed [ACC_WIDTH-1:0]  linebuf [LB_DEPTH];

   logic                         in_ready_c;
   logic                         accept_c;
   logic                         out_hs_c;
   logic                         cfg_ok_c;
   logic                         last_col_c;
   logic                         last_row_c;
   logic                         lb_we_c;
   logic [LB_AW-1:0]             lb_idx_c;
   logic signed [ACC_WIDTH-1:0]  x_ext_c;
   logic signed [ACC_WIDTH-1:0]  lb_rd_c;
   logic signed [ACC_WIDTH-1:0]  pair_c;
   logic signed [ACC_WIDTH-1:0]  quad_c;
   logic signed [DATA_WIDTH-1:0] pooled_c;

   // Max keeps the larger operand; avg accumulates (two guard bits cover a 4-element sum).
   function automatic logic signed [ACC_WIDTH-1:0] combine(
      input logic signed [ACC_WIDTH-1:0] a,
      input logic signed [ACC_WIDTH-1:0] b,
      input logic                        avg
   );
      logic signed [ACC_WIDTH-1:0] r;
      if (avg) begin
         r = a + b;
      end else begin
         r = (a > b) ? a : b;
      end
      return r;
   endfunction

   // Handshakes; the output register frees up in the same cycle it is drained.
   assign in_ready_c    = (state == RUN) && (!out_valid_q || out_bus.ready);
   assign accept_c      = in_bus.valid && in_ready_c;
   assign out_hs_c      = out_valid_q && out_bus.ready;
   assign in_bus.ready  = in_ready_c;
   assign out_bus.valid = out_valid_q;
   assign out_bus.data  = out_data_q;

   // Frame dimensions must be even, at least 2, and the width must fit the line buffer.
   assign cfg_ok_c = (frame_width[0] == 1'b0) && (frame_width >= DIM_WIDTH'(2)) &&
                     (32'(frame_width) <= MAX_WIDTH) &&
                     (frame_height[0] == 1'b0) && (frame_height >= DIM_WIDTH'(2));

   assign last_col_c = (col_q == width_q - DIM_WIDTH'(1));
   assign last_row_c = (row_q == height_q - DIM_WIDTH'(1));

   // Datapath: horizontal pair from hold + x, vertical combine with the stored upper pair.
   always_comb begin
      x_ext_c  = {{2{in_bus.data[DATA_WIDTH-1]}}, in_bus.data};
      lb_idx_c = LB_AW'(col_q >> 1);
      lb_rd_c  = linebuf[lb_idx_c];
      pair_c   = combine(hold_q, x_ext_c, mode_q);
      quad_c   = combine(pair_c, lb_rd_c, mode_q);
      // Arithmetic shift floors toward minus infinity; the quotient always fits DATA_WIDTH.
      pooled_c = mode_q ? DATA_WIDTH'(quad_c >>> 2) : DATA_WIDTH'(quad_c);
   end

   // State and control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mode_q      <= 1'b0;
         width_q     <= '0;
         height_q    <= '0;
         row_q       <= '0;
         col_q       <= '0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cfg_error   <= 1'b0;
      end else begin
         state       <= state_nx;
         mode_q      <= mode_nx;
         width_q     <= width_nx;
         height_q    <= height_nx;
         row_q       <= row_nx;
         col_q       <= col_nx;
         hold_q      <= hold_nx;
         out_valid_q <= out_valid_nx;
         out_data_q  <= out_data_nx;
         busy        <= busy_nx;
         done        <= done_nx;
         cfg_error   <= cfg_error_nx;
      end
   end

   // Line buffer of horizontal pair results from the even row; contents need no reset.
   always_ff @(posedge clk) begin
      if (lb_we_c) begin
         linebuf[lb_idx_c] <= pair_c;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_nx     = state;
      mode_nx      = mode_q;
      width_nx     = width_q;
      height_nx    = height_q;
      row_nx       = row_q;
      col_nx       = col_q;
      hold_nx      = hold_q;
      out_valid_nx = out_valid_q;
      out_data_nx  = out_data_q;
      busy_nx      = busy;
      done_nx      = 1'b0;
      cfg_error_nx = 1'b0;
      lb_we_c      = 1'b0;

      if (out_hs_c) begin
         out_valid_nx = 1'b0;
      end

      case (state)
         IDLE: begin
            if (start) begin
               if (cfg_ok_c) begin
                  mode_nx   = mode;
                  width_nx  = frame_width;
                  height_nx = frame_height;
                  row_nx    = '0;
                  col_nx    = '0;
                  busy_nx   = 1'b1;
                  state_nx  = RUN;
               end else begin
                  done_nx      = 1'b1;
                  cfg_error_nx = 1'b1;
                  state_nx     = DONE;
               end
            end
         end

         RUN: begin
            if (accept_c) begin
               // Even column opens a window pair; odd column closes it.
               if (!col_q[0]) begin
                  hold_nx = x_ext_c;
               end else if (!row_q[0]) begin
                  lb_we_c = 1'b1;
               end else begin
                  out_valid_nx = 1'b1;
                  out_data_nx  = pooled_c;
               end

               if (last_col_c) begin
                  col_nx = '0;
                  row_nx = row_q + DIM_WIDTH'(1);
               end else begin
                  col_nx = col_q + DIM_WIDTH'(1);
               end

               if (last_col_c && last_row_c) begin
                  state_nx = DRAIN;
               end
            end
         end

         DRAIN: begin
            if (out_hs_c) begin
               busy_nx  = 1'b0;
               done_nx  = 1'b1;
               state_nx = DONE;
            end
         end

         DONE: begin
            state_nx = IDLE;
         end

         default: begin
            state_nx = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_pool_engine.sv
// Directed bench for pool_engine: max/avg frames, backpressure, bad configs,
// mid-frame start, and asynchronous reset mid-frame.
module tb_pool_engine;

   localparam int unsigned DW = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mode;
   logic [7:0] fw;
   logic [7:0] fh;
   logic       busy;
   logic       done;
   logic       cfg_error;

   pool_engine_if #(.DATA_WIDTH(DW)) in_if ();
   pool_engine_if #(.DATA_WIDTH(DW)) out_if ();

   pool_engine #(
      .DATA_WIDTH (DW),
      .MAX_WIDTH  (64),
      .DIM_WIDTH  (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .frame_width  (fw),
      .frame_height (fh),
      .busy         (busy),
      .done         (done),
      .cfg_error    (cfg_error),
      .in_bus       (in_if),
      .out_bus      (out_if)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   int         last_hs_cyc = 0;
   int         done_cnt = 0;
   int         got[$];
   int         stim[$];
   int         expq[$];
   logic       bp_en  = 1'b0;
   logic       gap_en = 1'b0;
   logic [3:0] pat    = 4'b1001;
   int         pat_k  = 0;
   logic       prev_stall = 1'b0;
   int         prev_data  = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Sink ready: steady high, or the 1-0-0-1 pattern during the backpressure test.
   always @(posedge clk) begin
      #1;
      if (bp_en) begin
         out_if.ready = pat[pat_k];
         pat_k = (pat_k + 1) % 4;
      end else begin
         out_if.ready = 1'b1;
      end
   end

   // Output collector and stall invariants, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (out_if.valid && out_if.ready) begin
            got.push_back(int'(out_if.data));
            last_hs_cyc = cyc;
         end
         if (done) done_cnt++;
         if (prev_stall && out_if.valid) check_eq("bp_data_hold", int'(out_if.data), prev_data);
         if (out_if.valid && !out_if.ready) check_eq("bp_in_ready_low", int'(in_if.ready), 0);
         prev_stall = out_if.valid && !out_if.ready;
         prev_data  = int'(out_if.data);
      end
   end

   task automatic start_frame(input logic m, input int w, input int h);
      start = 1'b1;
      mode  = m;
      fw    = 8'(w);
      fh    = 8'(h);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input int x);
      logic ok;
      ok = 1'b0;
      if (gap_en) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      in_if.valid = 1'b1;
      in_if.data  = 8'(x);
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = in_if.ready;
         @(posedge clk); #1;
      end
      in_if.valid = 1'b0;
      if (!ok) check_eq("send_timeout", 0, 1);
   endtask

   task automatic run_frame(input string tag, input logic m, input int w, input int h,
                            input int start_at);
      int seen;
      int dcyc;
      int derr;
      seen = 0;
      dcyc = 0;
      derr = 0;
      got.delete();
      start_frame(m, w, h);
      check_eq({tag, "_busy"}, int'(busy), 1);
      foreach (stim[i]) begin
         if (i == start_at) start_frame(1'b1, 2, 2);
         send(stim[i]);
      end
      for (int i = 0; i < 300 && seen == 0; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            dcyc = cyc;
            derr = int'(cfg_error);
         end
      end
      check_eq({tag, "_done_seen"}, seen, 1);
      check_eq({tag, "_count"}, got.size(), expq.size());
      foreach (expq[i]) check_eq({tag, "_out"}, (i < got.size()) ? got[i] : -999, expq[i]);
      check_eq({tag, "_done_timing"}, dcyc, last_hs_cyc + 1);
      check_eq({tag, "_cfg_error"}, derr, 0);
      @(posedge clk); #1;
      check_eq({tag, "_busy_after"}, int'(busy), 0);
   endtask

   task automatic bad_cfg(input string tag, input int w);
      start_frame(1'b0, w, 2);
      @(negedge clk);
      check_eq({tag, "_done"}, int'(done), 1);
      check_eq({tag, "_cfg_error"}, int'(cfg_error), 1);
      check_eq({tag, "_busy"}, int'(busy), 0);
      check_eq({tag, "_in_ready"}, int'(in_if.ready), 0);
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, int'(done), 0);
      check_eq({tag, "_busy2"}, int'(busy), 0);
      check_eq({tag, "_in_ready2"}, int'(in_if.ready), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      rst          = 1'b1;
      start        = 1'b0;
      mode         = 1'b0;
      fw           = '0;
      fh           = '0;
      in_if.valid  = 1'b0;
      in_if.data   = '0;
      out_if.ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_cfg_error", int'(cfg_error), 0);
      check_eq("rst_in_ready", int'(in_if.ready), 0);
      check_eq("rst_out_valid", int'(out_if.valid), 0);
      check_eq("rst_out_data", int'(out_if.data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(i);
      expq = '{5, 7, 13, 15};
      run_frame("max4x4", 1'b0, 4, 4, -1);

      expq = '{2, 4, 10, 12};
      run_frame("avg4x4", 1'b1, 4, 4, -1);

      stim = '{-1, -2, -2, -2};
      expq = '{-2};
      run_frame("avg2x2_neg", 1'b1, 2, 2, -1);

      stim.delete();
      for (int i = 0; i < 16; i++) stim.push_back(i);
      expq   = '{5, 7, 13, 15};
      bp_en  = 1'b1;
      gap_en = 1'b1;
      run_frame("bp_max4x4", 1'b0, 4, 4, -1);
      bp_en  = 1'b0;
      gap_en = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end

      bad_cfg("bad_w3", 3);
      bad_cfg("bad_w0", 0);
      bad_cfg("bad_w66", 66);

      stim.delete();
      for (int i = 0; i < 8; i++) stim.push_back(i);
      expq = '{5, 7};
      run_frame("midstart", 1'b0, 4, 2, 3);

      start_frame(1'b0, 8, 8);
      for (int i = 0; i < 6; i++) send(i + 1);
      check_eq("pre_rst_busy", int'(busy), 1);
      dc = done_cnt;
      #2 rst = 1'b1;
      #1;
      check_eq("arst_busy", int'(busy), 0);
      check_eq("arst_done", int'(done), 0);
      check_eq("arst_cfg_error", int'(cfg_error), 0);
      check_eq("arst_in_ready", int'(in_if.ready), 0);
      check_eq("arst_out_valid", int'(out_if.valid), 0);
      check_eq("arst_out_data", int'(out_if.data), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check_eq("arst_no_done", done_cnt, dc);

      stim = '{1, 9, -3, 4};
      expq = '{9};
      run_frame("post_rst", 1'b0, 2, 2, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
